// File: rtl/regfile_write_sched.sv
// regfile_write_sched
//   Write-port scheduler for the 32x32 MIPS register file. The register
//   file has no reset, so after reset this block zeroes r1..r31 (when
//   INIT_EN=1). It then shares the single write port among three writeback
//   requesters using round-robin arbitration and a valid/ready handshake.
//
// Ports:
//   clk            rising-edge clock, shared with the register file
//   rst_n          asynchronous active-low reset
//   req_valid[2:0] per-requester write request (0 ALU, 1 load, 2 mult/div)
//   req_reg[14:0]  destination register, 5 bits per requester {r2,r1,r0}
//   req_data[95:0] write data, 32 bits per requester {d2,d1,d0}
//   req_ready[2:0] per-requester accept, one-hot or zero (combinational)
//   RegWrite       registered write enable to the register file
//   WriteRegister  registered write address
//   WriteData      registered write data
//   init_done      high once zeroing is complete, until the next reset
//
// The registered outputs double as the decode-stage bypass source: while
// RegWrite=1, WriteRegister/WriteData describe the pending write.
module regfile_write_sched #(
    parameter bit INIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_valid,
    input  logic [14:0] req_reg,
    input  logic [95:0] req_data,
    output logic [2:0]  req_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        init_done
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [4:0]  initCnt;

    logic [1:0]  order1;
    logic [1:0]  order2;
    logic        grantValid;
    logic [1:0]  grantIdx;
    logic [4:0]  grantReg;
    logic [31:0] grantData;

    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign order1 = nextIdx(ptr);
    assign order2 = nextIdx(order1);

    // Round-robin arbitration: search ptr, ptr+1, ptr+2 (mod 3). The
    // rst_n term keeps req_ready at zero while reset is held even when the
    // state register already reads RUN (INIT_EN=0).
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = 2'd0;
        req_ready  = '0;
        if (state == RUN && rst_n) begin
            if (req_valid[ptr]) begin
                grantValid = 1'b1;
                grantIdx   = ptr;
            end else if (req_valid[order1]) begin
                grantValid = 1'b1;
                grantIdx   = order1;
            end else if (req_valid[order2]) begin
                grantValid = 1'b1;
                grantIdx   = order2;
            end
        end
        if (grantValid) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        grantReg  = '0;
        grantData = '0;
        case (grantIdx)
            2'd0: begin
                grantReg  = req_reg[4:0];
                grantData = req_data[31:0];
            end
            2'd1: begin
                grantReg  = req_reg[9:5];
                grantData = req_data[63:32];
            end
            2'd2: begin
                grantReg  = req_reg[14:10];
                grantData = req_data[95:64];
            end
            default: begin
                grantReg  = '0;
                grantData = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT_EN ? INIT : RUN;
            init_done     <= !INIT_EN;
            ptr           <= 2'd0;
            initCnt       <= 5'd1;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            case (state)
                INIT: begin
                    RegWrite      <= 1'b1;
                    WriteRegister <= initCnt;
                    WriteData     <= '0;
                    initCnt       <= initCnt + 5'd1;
                    if (initCnt == 5'd31) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (grantValid) begin
                        WriteRegister <= grantReg;
                        WriteData     <= grantData;
                        // A write to $0 is accepted but never reaches the file.
                        RegWrite      <= (grantReg != 5'd0);
                        ptr           <= nextIdx(grantIdx);
                    end else begin
                        RegWrite <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
module tb_regfile_write_sched;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_reg;
    logic [95:0] req_data;

    logic [2:0]  req_ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        init_done;

    logic [2:0]  ready0;
    logic        regWrite0;
    logic [4:0]  writeReg0;
    logic [31:0] writeData0;
    logic        initDone0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t expQ[$];

    // Register file fed by the main DUT; starts with garbage so that the
    // zeroing sequence is observable. r0 is hardwired to zero.
    logic [31:0] rf [32] = '{default: 32'hA5A5A5A5};

    regfile_write_sched #(.INIT_EN(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .init_done     (init_done)
    );

    regfile_write_sched #(.INIT_EN(1'b0)) dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .req_ready     (ready0),
        .RegWrite      (regWrite0),
        .WriteRegister (writeReg0),
        .WriteData     (writeData0),
        .init_done     (initDone0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegWrite && WriteRegister != 5'd0) begin
            rf[WriteRegister] <= WriteData;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive requests, check ready before the edge, queue
    // the expected write, then compare the registered outputs after the edge.
    task automatic step(input logic [2:0] v, input logic [14:0] r, input logic [95:0] d,
                        input logic [2:0] expReady, input logic expWe,
                        input logic [4:0] expReg, input logic [31:0] expData);
        exp_t e;
        req_valid = v;
        req_reg   = r;
        req_data  = d;
        #1;
        check("req_ready", {93'd0, req_ready}, {93'd0, expReady});
        expQ.push_back('{we: expWe, r: expReg, d: expData});
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = expQ.pop_front();
            check("RegWrite", {95'd0, RegWrite}, {95'd0, e.we});
            check("WriteRegister", {91'd0, WriteRegister}, {91'd0, e.r});
            check("WriteData", {64'd0, WriteData}, {64'd0, e.d});
        end
        @(negedge clk);
    endtask

    task automatic runInit();
        for (int k = 1; k <= 31; k++) begin
            check("init_done_low", {95'd0, init_done}, 96'd0);
            step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1},
                 3'b000, 1'b1, 5'(k), 32'h0);
        end
        check("init_done_high", {95'd0, init_done}, 96'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_reg   = '0;
        req_data  = '0;
        #12;
        check("rst_RegWrite", {95'd0, RegWrite}, 96'd0);
        check("rst_WriteRegister", {91'd0, WriteRegister}, 96'd0);
        check("rst_WriteData", {64'd0, WriteData}, 96'd0);
        check("rst_init_done", {95'd0, init_done}, 96'd0);
        check("rst_req_ready", {93'd0, req_ready}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runInit();

        // ALU only, ptr=0
        step(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF},
             3'b001, 1'b1, 5'd5, 32'hDEADBEEF);
        for (int k = 1; k <= 31; k++) begin
            check("rf_zeroed", {64'd0, rf[k]}, 96'd0);
        end
        step(3'b000, '0, '0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF);
        check("rf_r5", {64'd0, rf[5]}, {64'd0, 32'hDEADBEEF});

        // ptr=1: mult/div only, brings ptr back to 0
        step(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0},
             3'b100, 1'b1, 5'd9, 32'h99);

        // All valid held: grants 0,1,2,0,1,2
        step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 3'b001, 1'b1, 5'd10, 32'hA0);
        step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 3'b010, 1'b1, 5'd11, 32'hA1);
        step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 3'b100, 1'b1, 5'd12, 32'hA2);
        step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 3'b001, 1'b1, 5'd10, 32'hA0);
        step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 3'b010, 1'b1, 5'd11, 32'hA1);
        step(3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 3'b100, 1'b1, 5'd12, 32'hA2);

        // Load writes $0: accepted, RegWrite stays low, ptr -> 2
        step(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0},
             3'b010, 1'b0, 5'd0, 32'h1234);
        // ptr=2 with ALU+load valid: order 2,0,1 picks ALU
        step(3'b011, {5'd0, 5'd4, 5'd3}, {32'h0, 32'h44, 32'h33},
             3'b001, 1'b1, 5'd3, 32'h33);

        // Same destination from all three, ptr=1: grant order 1,2,0
        step(3'b111, {5'd20, 5'd20, 5'd20}, {32'hC2, 32'hC1, 32'hC0}, 3'b010, 1'b1, 5'd20, 32'hC1);
        step(3'b111, {5'd20, 5'd20, 5'd20}, {32'hC2, 32'hC1, 32'hC0}, 3'b100, 1'b1, 5'd20, 32'hC2);
        step(3'b111, {5'd20, 5'd20, 5'd20}, {32'hC2, 32'hC1, 32'hC0}, 3'b001, 1'b1, 5'd20, 32'hC0);
        step(3'b000, '0, '0, 3'b000, 1'b0, 5'd20, 32'hC0);
        check("rf_last_wins", {64'd0, rf[20]}, {64'd0, 32'hC0});

        // Reset while RegWrite=1
        step(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77},
             3'b001, 1'b1, 5'd7, 32'h77);
        req_valid = 3'b111;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_RegWrite", {95'd0, RegWrite}, 96'd0);
        check("midrst_init_done", {95'd0, init_done}, 96'd0);
        check("midrst_WriteRegister", {91'd0, WriteRegister}, 96'd0);
        check("midrst_req_ready", {93'd0, req_ready}, 96'd0);
        check("dut0_rst_init_done", {95'd0, initDone0}, 96'd1);
        check("dut0_rst_RegWrite", {95'd0, regWrite0}, 96'd0);
        check("dut0_rst_ready", {93'd0, ready0}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runInit();
        // ptr must be back at 0
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'h57, 32'h56, 32'h55},
             3'b001, 1'b1, 5'd1, 32'h55);

        // INIT_EN=0 instance: grant on the first edge after reset
        req_valid = 3'b000;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 3'b100;
        req_reg   = {5'd31, 5'd0, 5'd0};
        req_data  = {32'd7, 32'd0, 32'd0};
        #1;
        check("dut0_ready", {93'd0, ready0}, {93'd0, 3'b100});
        check("dut0_init_done", {95'd0, initDone0}, 96'd1);
        check("init_ready_blocked", {93'd0, req_ready}, 96'd0);
        @(posedge clk);
        #1;
        check("dut0_RegWrite", {95'd0, regWrite0}, 96'd1);
        check("dut0_WriteRegister", {91'd0, writeReg0}, 96'd31);
        check("dut0_WriteData", {64'd0, writeData0}, 96'd7);
        check("init_first_write", {91'd0, WriteRegister}, 96'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
